// File: rtl/rotate_scan_if.sv
// Source-read and pixel-output signal bundle for the rotation scan controller.
// The master side is the controller; the slave side is memory plus output writer.
interface rotate_scan_if #(
  parameter int ADDR_W = 16
) ();
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              rd_valid;
  logic [7:0]        rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_data;
  logic              out_last;

  modport master (
    output rd_req, rd_addr, out_valid, out_data, out_last,
    input  rd_gnt, rd_valid, rd_data, out_ready
  );

  modport slave (
    input  rd_req, rd_addr, out_valid, out_data, out_last,
    output rd_gnt, rd_valid, rd_data, out_ready
  );
endinterface

// File: rtl/rotate_scan_ctrl.sv
// Raster scan of the destination canvas with incremental inverse rotation (Q.15),
// fetching in-range source pixels one at a time and streaming them out.
module rotate_scan_ctrl #(
  parameter int         SRC_ROWS = 242,
  parameter int         SRC_COLS = 247,
  parameter int         DST_DIM  = 346,
  parameter int         ADDR_W   = 16,
  parameter int         TRIG_W   = 16,
  parameter logic [7:0] FILL     = 8'd0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [TRIG_W-1:0] cos_q,
  input  logic signed [TRIG_W-1:0] sin_q,
  output logic                     busy,
  output logic                     done,
  rotate_scan_if.master            bus
);
  localparam int ACC_W = 36;
  localparam int CNT_W = $clog2(DST_DIM);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DST_DIM - 1);
  // (DST_DIM-1)*trig in Q1.14 equals dcx*trig in Q.15 exactly.
  localparam logic signed [ACC_W-1:0] K_DIM  = ACC_W'(DST_DIM - 1);
  localparam logic signed [ACC_W-1:0] SCX_Q  = ACC_W'((SRC_COLS - 1) * 16384);
  localparam logic signed [ACC_W-1:0] SCY_Q  = ACC_W'((SRC_ROWS - 1) * 16384);
  localparam logic signed [ACC_W-1:0] ROUND  = ACC_W'(16384);
  localparam logic signed [ACC_W-1:0] SC_LIM = ACC_W'(SRC_COLS);
  localparam logic signed [ACC_W-1:0] SR_LIM = ACC_W'(SRC_ROWS);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_MAP, S_FETCH, S_WAIT, S_EMIT} state_t;

  state_t                    r_state, w_next;
  logic signed [TRIG_W-1:0]  r_cos, r_sin;
  logic [1:0]                r_setup;
  logic signed [ACC_W-1:0]   r_mc, r_ms;
  logic signed [ACC_W-1:0]   r_x, r_y, r_xr, r_yr;
  logic [CNT_W-1:0]          r_row, r_col;
  logic [ADDR_W-1:0]         r_addr;
  logic [7:0]                r_data;
  logic                      r_done;

  logic signed [ACC_W-1:0]   w_cos_ext, w_sin_ext, w_cos2, w_sin2;
  logic signed [ACC_W-1:0]   w_mul_op, w_prod, w_x0, w_y0, w_sx, w_sy;
  logic [ADDR_W-1:0]         w_addr;
  logic                      w_in_range, w_last_px, w_hs;
  logic                      w_busy, w_rd_req, w_out_valid;

  assign w_cos_ext = {{(ACC_W-TRIG_W){r_cos[TRIG_W-1]}}, r_cos};
  assign w_sin_ext = {{(ACC_W-TRIG_W){r_sin[TRIG_W-1]}}, r_sin};
  assign w_cos2    = w_cos_ext <<< 1;
  assign w_sin2    = w_sin_ext <<< 1;

  // Single multiplier shared across the SETUP cycles.
  assign w_mul_op  = r_setup[0] ? w_sin_ext : w_cos_ext;
  assign w_prod    = w_mul_op * K_DIM;
  assign w_x0      = SCX_Q - r_mc - r_ms;
  assign w_y0      = SCY_Q + r_ms - r_mc;

  assign w_sx       = (r_x + ROUND) >>> 15;
  assign w_sy       = (r_y + ROUND) >>> 15;
  assign w_in_range = !w_sx[ACC_W-1] && (w_sx < SC_LIM) && !w_sy[ACC_W-1] && (w_sy < SR_LIM);
  assign w_addr     = w_sy[ADDR_W-1:0] * ADDR_W'(SRC_COLS) + w_sx[ADDR_W-1:0];
  assign w_last_px  = (r_row == LAST) && (r_col == LAST);
  assign w_hs       = (r_state == S_EMIT) && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every output of this block gets a default before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_next      = r_state;
    w_busy      = 1'b1;
    w_rd_req    = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (start) w_next = S_SETUP;
      end
      S_SETUP: if (r_setup == 2'd2) w_next = S_MAP;
      S_MAP:   w_next = w_in_range ? S_FETCH : S_EMIT;
      S_FETCH: begin
        w_rd_req = 1'b1;
        if (bus.rd_gnt) w_next = S_WAIT;
      end
      S_WAIT:  if (bus.rd_valid) w_next = S_EMIT;
      S_EMIT: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_next = w_last_px ? S_IDLE : S_MAP;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register here updates from pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cos <= '0; r_sin <= '0; r_setup <= '0; r_mc <= '0; r_ms <= '0;
      r_x <= '0; r_y <= '0; r_xr <= '0; r_yr <= '0;
      r_row <= '0; r_col <= '0; r_addr <= '0; r_data <= '0; r_done <= 1'b0;
    end else begin
      r_done <= w_hs && w_last_px;
      case (r_state)
        S_IDLE: if (start) begin
          r_cos   <= cos_q;
          r_sin   <= sin_q;
          r_setup <= '0;
          r_row   <= '0;
          r_col   <= '0;
        end
        S_SETUP: begin
          r_setup <= r_setup + 2'd1;
          if (r_setup == 2'd0) r_mc <= w_prod;
          if (r_setup == 2'd1) r_ms <= w_prod;
          if (r_setup == 2'd2) begin
            r_x <= w_x0; r_xr <= w_x0;
            r_y <= w_y0; r_yr <= w_y0;
          end
        end
        S_MAP: begin
          if (w_in_range) r_addr <= w_addr;
          else            r_data <= FILL;
        end
        S_WAIT: if (bus.rd_valid) r_data <= bus.rd_data;
        S_EMIT: if (bus.out_ready) begin
          // Row wrap reloads the column accumulators from the row accumulators.
          if (r_col == LAST) begin
            r_col <= '0;
            r_row <= r_row + CNT_W'(1);
            r_xr  <= r_xr + w_sin2;
            r_yr  <= r_yr + w_cos2;
            r_x   <= r_xr + w_sin2;
            r_y   <= r_yr + w_cos2;
          end else begin
            r_col <= r_col + CNT_W'(1);
            r_x   <= r_x + w_cos2;
            r_y   <= r_y - w_sin2;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy          = w_busy;
  assign done          = r_done;
  assign bus.rd_req    = w_rd_req;
  assign bus.rd_addr   = r_addr;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_data;
  assign bus.out_last  = w_out_valid && w_last_px;
endmodule

// File: tb/tb_rotate_scan_ctrl.sv
// Scoreboard bench for rotate_scan_ctrl on a reduced 12x13 source / 18x18 canvas;
// expected beats and read addresses come from a direct real-valued rotation model.
module tb_rotate_scan_ctrl;
  localparam int         SR = 12;
  localparam int         SC = 13;
  localparam int         DD = 18;
  localparam int         AW = 16;
  localparam int         TW = 16;
  localparam logic [7:0] FILL_V = 8'hEE;
  localparam int         BUDGET = 20000;

  logic                 clk = 1'b0;
  logic                 rst, start, busy, done;
  logic signed [TW-1:0] cos_q, sin_q;

  rotate_scan_if #(.ADDR_W(AW)) bus ();

  rotate_scan_ctrl #(
    .SRC_ROWS(SR), .SRC_COLS(SC), .DST_DIM(DD), .ADDR_W(AW), .TRIG_W(TW), .FILL(FILL_V)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cos_q(cos_q), .sin_q(sin_q),
    .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t exp_beats[$];
  int    exp_reads[$];
  int    n_checks = 0, n_fail = 0;
  int    cyc = 0, beats = 0, reads = 0, busy_cyc = 0, done_cnt = 0, last_hs_cyc = -10;
  int    first_rd = -1, last_rd = -1;
  bit    ready_rand = 0, spur_en = 0;
  int    gnt_max = 0, lat_max = 0;
  bit    data_pending = 0;
  int    data_wait = 0, gnt_wait = 0;
  logic [AW-1:0] pend_addr = '0;

  // Source memory: data = addr[7:0], random grant wait and data latency.
  initial begin
    bus.rd_gnt = 1'b0; bus.rd_valid = 1'b0; bus.rd_data = 8'h00;
    forever begin
      int e;
      @(negedge clk);
      bus.rd_valid = 1'b0;
      bus.rd_data  = 8'h00;
      if (data_pending) begin
        if (data_wait == 0) begin
          bus.rd_valid = 1'b1; bus.rd_data = pend_addr[7:0]; data_pending = 0;
        end else data_wait--;
      end else if (spur_en && $urandom_range(0, 7) == 0) begin
        bus.rd_valid = 1'b1; bus.rd_data = 8'hA5;
      end
      bus.rd_gnt = 1'b0;
      if (!rst && bus.rd_req === 1'b1 && !data_pending) begin
        if (gnt_wait > 0) gnt_wait--;
        else begin
          bus.rd_gnt   = 1'b1;
          data_pending = 1;
          data_wait    = $urandom_range(0, lat_max);
          gnt_wait     = $urandom_range(0, gnt_max);
          pend_addr    = bus.rd_addr;
          reads++;
          if (first_rd < 0) first_rd = int'(bus.rd_addr);
          last_rd = int'(bus.rd_addr);
          n_checks++;
          if (exp_reads.size() == 0) begin
            n_fail++;
            $display("FAIL read_addr: got unexpected read of %0d, required no read", bus.rd_addr);
          end else begin
            e = exp_reads.pop_front();
            if (bus.rd_addr !== AW'(e)) begin
              n_fail++;
              $display("FAIL read_addr: got %0d required %0d", bus.rd_addr, e);
            end
          end
        end
      end
    end
  end

  // Output sink: drives out_ready, pops the scoreboard on handshakes, checks stall hold and done timing.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;
    beat_t      b;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      bus.out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (busy === 1'b1) busy_cyc++;
      if (prev_stall) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data || bus.out_last !== prev_last) begin
          n_fail++;
          $display("FAIL stall_hold: got valid=%b data=%h last=%b required valid=1 data=%h last=%b",
                   bus.out_valid, bus.out_data, bus.out_last, prev_data, prev_last);
        end
      end
      prev_stall = 1'b0;
      if (!rst && bus.out_valid === 1'b1) begin
        if (!bus.out_ready) begin
          prev_stall = 1'b1; prev_data = bus.out_data; prev_last = bus.out_last;
        end else begin
          beats++;
          n_checks++;
          if (exp_beats.size() == 0) begin
            n_fail++;
            $display("FAIL beat: got unexpected beat data=%h, required no beat", bus.out_data);
          end else begin
            b = exp_beats.pop_front();
            if (bus.out_data !== b.data || bus.out_last !== b.last) begin
              n_fail++;
              $display("FAIL beat %0d: got data=%h last=%b required data=%h last=%b",
                       beats - 1, bus.out_data, bus.out_last, b.data, b.last);
            end
          end
          if (bus.out_last === 1'b1) last_hs_cyc = cyc;
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        n_checks++;
        if (last_hs_cyc != cyc - 1) begin
          n_fail++;
          $display("FAIL done_timing: got done at cycle %0d, required cycle %0d", cyc, last_hs_cyc + 1);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no end of test, required completion within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic push_frame(input int cq, input int sq, output int nrd);
    real   cr, sr, dc, vx, vy;
    int    sx, sy;
    beat_t b;
    cr = real'(cq) / 16384.0;
    sr = real'(sq) / 16384.0;
    dc = (DD - 1) / 2.0;
    nrd = 0;
    for (int r = 0; r < DD; r++) begin
      for (int c = 0; c < DD; c++) begin
        vx = (SC - 1) / 2.0 + (c - dc) * cr + (r - dc) * sr;
        vy = (SR - 1) / 2.0 - (c - dc) * sr + (r - dc) * cr;
        sx = int'($floor(vx + 0.5));
        sy = int'($floor(vy + 0.5));
        b.last = (r == DD - 1) && (c == DD - 1);
        if (sx >= 0 && sx < SC && sy >= 0 && sy < SR) begin
          exp_reads.push_back(sy * SC + sx);
          b.data = 8'((sy * SC + sx) & 255);
          nrd++;
        end else b.data = FILL_V;
        exp_beats.push_back(b);
      end
    end
  endtask

  task automatic pulse_start(input int c, input int s, input bit push, output int nrd);
    @(posedge clk); #1;
    cos_q = TW'(c); sin_q = TW'(s); start = 1'b1; nrd = 0;
    if (push) push_frame(c, s, nrd);
    @(posedge clk); #1;
    start = 1'b0; cos_q = 16'sh2AAA; sin_q = -16'sh1555;
  endtask

  task automatic wait_done(output bit ok);
    int d0;
    d0 = done_cnt; ok = 0;
    for (int i = 0; i < BUDGET && !ok; i++) begin
      @(posedge clk);
      if (done_cnt != d0) ok = 1;
    end
    #1;
  endtask

  task automatic clear_counts();
    beats = 0; reads = 0; busy_cyc = 0; first_rd = -1; last_rd = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cos_q = '0; sin_q = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, done, bus.rd_req, bus.out_valid, bus.out_last} !== 5'b0 || bus.rd_addr !== '0 || bus.out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b req=%b valid=%b last=%b addr=%h data=%h required all 0",
               busy, done, bus.rd_req, bus.out_valid, bus.out_last, bus.rd_addr, bus.out_data);
    end
    @(posedge clk); #1; rst = 1'b0;
    repeat (4) @(posedge clk);
    n_checks++;
    if (busy !== 1'b0 || done_cnt != 0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b done_count=%0d required 0 and 0", busy, done_cnt);
    end
  endtask

  task automatic test_angle0();
    int nrd, pix, d0;
    bit ok;
    ready_rand = 0; gnt_max = 0; lat_max = 0; spur_en = 0;
    clear_counts(); d0 = done_cnt;
    pulse_start(16384, 0, 1, nrd);
    wait_done(ok);
    pix = 2 * (DD * DD - nrd) + 4 * nrd;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL a0_done: got no done within %0d cycles, required done", BUDGET); end
    n_checks++;
    if (reads != 156 || beats != DD * DD) begin
      n_fail++; $display("FAIL a0_counts: got reads=%0d beats=%0d required 156 and %0d", reads, beats, DD * DD);
    end
    n_checks++;
    if (first_rd != 0 || last_rd != SR * SC - 1) begin
      n_fail++; $display("FAIL a0_corners: got first=%0d last=%0d required 0 and %0d", first_rd, last_rd, SR * SC - 1);
    end
    n_checks++;
    if (busy_cyc < pix + 1 || busy_cyc > pix + 8) begin
      n_fail++; $display("FAIL a0_throughput: got %0d busy cycles required %0d..%0d", busy_cyc, pix + 1, pix + 8);
    end
    n_checks++;
    if (exp_beats.size() != 0 || exp_reads.size() != 0 || done_cnt != d0 + 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL a0_end: got beats_left=%0d reads_left=%0d dones=%0d busy=%b required 0 0 1 0",
                         exp_beats.size(), exp_reads.size(), done_cnt - d0, busy);
    end
  endtask

  task automatic test_angle(input int cq, input int sq, input bit stall);
    int nrd;
    bit ok;
    ready_rand = stall; gnt_max = stall ? 5 : 0; lat_max = stall ? 5 : 0; spur_en = stall;
    clear_counts();
    pulse_start(cq, sq, 1, nrd);
    wait_done(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL angle_done cos=%0d: got no done, required done", cq); end
    n_checks++;
    if (reads != nrd || beats != DD * DD) begin
      n_fail++; $display("FAIL angle_counts cos=%0d: got reads=%0d beats=%0d required %0d and %0d", cq, reads, beats, nrd, DD * DD);
    end
    n_checks++;
    if (exp_beats.size() != 0 || exp_reads.size() != 0) begin
      n_fail++; $display("FAIL angle_drain cos=%0d: got %0d beats %0d reads left required 0", cq, exp_beats.size(), exp_reads.size());
    end
    ready_rand = 0; spur_en = 0;
  endtask

  task automatic test_back_to_back();
    int nrd1, nrd2, dummy;
    bit ok, seen;
    ready_rand = 0; gnt_max = 1; lat_max = 2; spur_en = 0;
    clear_counts();
    pulse_start(16384, 0, 1, nrd1);
    repeat (100) @(posedge clk);
    pulse_start(0, 16384, 0, dummy);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL start_ignored_busy: got busy=%b required 1", busy); end
    seen = 0;
    for (int i = 0; i < BUDGET && !seen; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL b2b_first_done: got no done, required done"); end
    cos_q = 16'sd14189; sin_q = 16'sd8192; start = 1'b1;
    push_frame(14189, 8192, nrd2);
    @(posedge clk); #1;
    start = 1'b0; cos_q = '0; sin_q = '0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL start_at_done: got busy=%b required 1", busy); end
    wait_done(ok);
    n_checks++;
    if (!ok || reads != nrd1 + nrd2 || beats != 2 * DD * DD || exp_beats.size() != 0) begin
      n_fail++; $display("FAIL b2b_counts: got ok=%b reads=%0d beats=%0d required 1 %0d %0d",
                         ok, reads, beats, nrd1 + nrd2, 2 * DD * DD);
    end
  endtask

  task automatic test_reset_abort();
    int nrd, d0;
    bit hit, ok;
    ready_rand = 0; gnt_max = 1; lat_max = 5; spur_en = 0;
    clear_counts();
    pulse_start(14189, 8192, 1, nrd);
    hit = 0;
    for (int i = 0; i < BUDGET && !hit; i++) begin
      @(posedge clk); #1;
      if (beats >= 100 && data_pending && data_wait >= 2) hit = 1;
    end
    n_checks++;
    if (!hit) begin n_fail++; $display("FAIL abort_setup: got no outstanding read after beat 100, required one"); end
    rst = 1'b1; d0 = done_cnt;
    exp_beats.delete(); exp_reads.delete();
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, done, bus.rd_req, bus.out_valid, bus.out_last} !== 5'b0 || bus.rd_addr !== '0 || bus.out_data !== '0) begin
      n_fail++;
      $display("FAIL abort_state: got busy=%b done=%b req=%b valid=%b last=%b addr=%h data=%h required all 0",
               busy, done, bus.rd_req, bus.out_valid, bus.out_last, bus.rd_addr, bus.out_data);
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || done_cnt != d0) begin
      n_fail++; $display("FAIL late_rd_valid: got busy=%b valid=%b data=%h dones=%0d required 0 0 00 0",
                         busy, bus.out_valid, bus.out_data, done_cnt - d0);
    end
    clear_counts();
    pulse_start(14189, 8192, 1, nrd);
    wait_done(ok);
    n_checks++;
    if (!ok || reads != nrd || beats != DD * DD || exp_beats.size() != 0) begin
      n_fail++; $display("FAIL abort_restart: got ok=%b reads=%0d beats=%0d required 1 %0d %0d", ok, reads, beats, nrd, DD * DD);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cos_q = '0; sin_q = '0;
    test_reset();
    test_angle0();
    test_angle(0, 16384, 0);
    test_angle(14189, 8192, 0);
    test_angle(14189, 8192, 1);
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rotate_scan_ctrl.md
Name: rotate_scan_ctrl

Overview:
Frame-level sequencer for inverse-mapped image rotation. It scans every pixel of the square destination canvas in raster order and computes the source coordinate of each one with incremental fixed-point rotation. It then either fetches the source pixel through a single-outstanding read port or substitutes the fill value, and streams the result on a valid/ready output. It sits between the source pixel memory (loaded from the input frame) and the output writer.

Parameters:
SRC_ROWS, 242, source image height
SRC_COLS, 247, source image width
DST_DIM, 346, destination canvas side, ceil(sqrt(SRC_ROWS^2+SRC_COLS^2))
ADDR_W, 16, source address width; must satisfy SRC_ROWS*SRC_COLS <= 2^ADDR_W
TRIG_W, 16, signed Q1.14 width of cos/sin inputs
FILL, 8'd0, value emitted for destination pixels that map outside the source

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse that begins a frame; ignored while busy
cos_q  in  TRIG_W  signed Q1.14 cos(angle); sampled on accepted start
sin_q  in  TRIG_W  signed Q1.14 sin(angle); sampled on accepted start
busy  out  1  high from the cycle after an accepted start through the final output beat
done  out  1  one-cycle pulse in the cycle after the final beat handshakes
rd_req  out  1  source read request
rd_addr  out  ADDR_W  source address = sy*SRC_COLS + sx
rd_gnt  in  1  memory accepts the request this cycle
rd_valid  in  1  read data valid; arrives 1 or more cycles after rd_gnt
rd_data  in  8  source pixel
out_valid  out  1  output pixel valid
out_ready  in  1  downstream accepts
out_data  out  8  destination pixel
out_last  out  1  high with the beat for destination (DST_DIM-1, DST_DIM-1)

Behaviour:
- Reset (synchronous, active-high): FSM to IDLE; busy, done, rd_req, out_valid and out_last are 0; rd_addr and out_data are 0; counters are 0. Reset mid-frame aborts the frame immediately with no done pulse. A rd_valid arriving after reset is ignored.
- FSM states:
  - IDLE: on start, latch cos_q/sin_q and go to SETUP.
  - SETUP: up to 8 cycles; compute the frame origin with one shared multiplier, then go to MAP.
  - MAP: one cycle. Round the accumulators, bounds-check, go to FETCH if in range, else to EMIT with out_data=FILL.
  - FETCH: hold rd_req=1 and rd_addr stable until rd_gnt, then go to WAIT.
  - WAIT: on rd_valid, capture rd_data into out_data and go to EMIT.
  - EMIT: hold out_valid and stable out_data/out_last until out_ready. On handshake, step the counters and accumulators, then go to MAP, or to IDLE with done=1 after the last pixel.
- Arithmetic:
  - Internal accumulators are Q.15 signed, 36 bits.
  - Centers: dcx = dcy = (DST_DIM-1)/2, scx = (SRC_COLS-1)/2, scy = (SRC_ROWS-1)/2; all are exact in Q.15.
  - Frame origin: X0 = scx - dcx*cos - dcy*sin; Y0 = scy + dcx*sin - dcy*cos.
  - Column step: x += 2*cos_q, y -= 2*sin_q (Q1.14 to Q.15).
  - Row step: row accumulators xr += 2*sin_q, yr += 2*cos_q; at column 0, x = xr and y = yr.
  - Pure adds after SETUP, so there is no drift over the frame.
  - Rounding: sx = (x + 2^14) >>> 15 (floor of value+0.5); same for sy.
  - In range iff 0 <= sx < SRC_COLS and 0 <= sy < SRC_ROWS; otherwise no read is issued.
- Order and counts:
  - Raster order: row-major, column fastest.
  - Exactly DST_DIM^2 output beats per frame (119716 at defaults).
  - out_last is high on the final beat only.
- Throughput and latency:
  - At most one read outstanding.
  - Fill pixel: 2 cycles/pixel with out_ready held high.
  - Fetched pixel: 3 + (gnt wait) + (data latency) cycles.
- Boundaries:
  - out_ready low: the beat is held indefinitely with no state advance.
  - start while busy: ignored; sampled trig unchanged.
  - start in the same cycle as done: accepted.
  - rd_valid without an outstanding request: ignored.

Test Plan:
- Angle 0 (cos_q=16384, sin_q=0), memory data = addr[7:0], out_ready=1 -> dest (0,0)=FILL with no rd_req; dest (52,49) reads addr 0; dest (293,295) reads addr 59773; dest (52,48) and (52,296) = FILL; exactly 59774 reads, 119716 beats, out_last on the final beat, done 1 cycle later.
- Angle 90 (cos_q=0, sin_q=16384) -> every emitted pixel equals an independent real-valued inverse-rotation model rounded floor(v+0.5); read count equals the model's in-range count.
- Random out_ready (50%) and rd_gnt/rd_valid delays of 0-5 cycles at angle 30 (cos_q=14189, sin_q=8192) -> out_data/out_last stable while stalled; beat sequence identical to the no-stall run.
- Reset asserted at beat 1000 with a read outstanding -> next cycle all outputs 0 and busy=0; the late rd_valid is ignored; a new start produces a full correct frame.
- start pulsed mid-frame with different trig -> ignored; frame completes with the original angle; start coincident with done -> second frame begins.
